// File: rtl/ins_synth.sv
// Instruction synthesizer: encodes LI/BEQ/J requests into one or two MIPS words
// and streams them out over a valid/ready handshake toward the injection FIFO.
module ins_synth (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [4:0]  req_rs,
    input  logic [4:0]  req_rt,
    input  logic [31:0] req_value,
    input  logic [31:0] req_pc,
    output logic        ins_valid,
    input  logic        ins_ready,
    output logic [31:0] ins_word,
    output logic        ins_last,
    output logic        ins_err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EMIT1 = 2'd1,
        EMIT2 = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] w0;
        logic [31:0] w1;
        logic        two;
        logic        err;
    } enc_t;

    state_t      state_r;
    state_t      state_next_s;
    logic [31:0] w0_r;
    logic [31:0] w1_r;
    logic        two_r;
    logic        err_r;
    logic        accept_s;
    enc_t        enc_s;

    // Shortest legal encoding; an illegal request collapses to a single nop with err set.
    function automatic enc_t encode(
        input logic [2:0]  op,
        input logic [4:0]  rs,
        input logic [4:0]  rt,
        input logic [31:0] value,
        input logic [31:0] pc
    );
        enc_t        e;
        logic [31:0] npc;
        logic [31:0] diff;
        e    = '{w0: 32'h0, w1: 32'h0, two: 1'b0, err: 1'b0};
        npc  = pc + 32'd4;
        diff = value - npc;
        case (op)
            3'b000: begin
                if (value[31:15] == {17{value[15]}}) begin
                    e.w0 = {6'h09, 5'd0, rt, value[15:0]};
                end else if (value[31:16] == 16'h0) begin
                    e.w0 = {6'h0D, 5'd0, rt, value[15:0]};
                end else if (value[15:0] == 16'h0) begin
                    e.w0 = {6'h0F, 5'd0, rt, value[31:16]};
                end else begin
                    e.w0  = {6'h0F, 5'd0, rt, value[31:16]};
                    e.w1  = {6'h0D, rt, rt, value[15:0]};
                    e.two = 1'b1;
                end
            end
            3'b001: begin
                if ((diff[1:0] == 2'b00) && (diff[31:17] == {15{diff[17]}})) begin
                    e.w0 = {6'h04, rs, rt, diff[17:2]};
                end else begin
                    e.err = 1'b1;
                end
            end
            3'b010: begin
                if ((value[1:0] == 2'b00) && (value[31:28] == npc[31:28])) begin
                    e.w0 = {6'h02, value[27:2]};
                end else begin
                    e.err = 1'b1;
                end
            end
            default: begin
                e.err = 1'b1;
            end
        endcase
        return e;
    endfunction

    assign enc_s    = encode(req_op, req_rs, req_rt, req_value, req_pc);
    assign accept_s = (state_r == IDLE) && req_valid;

    // State register and request capture; inputs are only sampled on acceptance.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            w0_r    <= 32'h0;
            w1_r    <= 32'h0;
            two_r   <= 1'b0;
            err_r   <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (accept_s) begin
                w0_r  <= enc_s.w0;
                w1_r  <= enc_s.w1;
                two_r <= enc_s.two;
                err_r <= enc_s.err;
            end
        end
    end

    // Next-state logic; ins_ready only matters while a word is on offer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    state_next_s = EMIT1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            EMIT1: begin
                if (ins_ready) begin
                    state_next_s = two_r ? EMIT2 : IDLE;
                end else begin
                    state_next_s = EMIT1;
                end
            end
            EMIT2: begin
                if (ins_ready) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = EMIT2;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Output decode, driven purely from registered state and captured words.
    always_comb begin
        req_ready = 1'b0;
        ins_valid = 1'b0;
        ins_word  = 32'h0;
        ins_last  = 1'b0;
        ins_err   = 1'b0;
        case (state_r)
            IDLE: begin
                req_ready = 1'b1;
            end
            EMIT1: begin
                ins_valid = 1'b1;
                ins_word  = w0_r;
                ins_last  = ~two_r;
                ins_err   = err_r;
            end
            EMIT2: begin
                ins_valid = 1'b1;
                ins_word  = w1_r;
                ins_last  = 1'b1;
            end
            default: begin
                req_ready = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_ins_synth.sv
// Bench for ins_synth: directed vector table, random requests against an
// arithmetic reference model, and hand-written backpressure/reset/streaming sequences.
module tb_ins_synth;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_op;
    logic [4:0]  req_rs;
    logic [4:0]  req_rt;
    logic [31:0] req_value;
    logic [31:0] req_pc;
    logic        ins_valid;
    logic        ins_ready;
    logic [31:0] ins_word;
    logic        ins_last;
    logic        ins_err;

    int checks   = 0;
    int failures = 0;

    ins_synth dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rs(req_rs), .req_rt(req_rt),
        .req_value(req_value), .req_pc(req_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready),
        .ins_word(ins_word), .ins_last(ins_last), .ins_err(ins_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          n;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        err;
    } exp_t;

    typedef struct {
        logic [2:0]  op;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [31:0] value;
        logic [31:0] pc;
        int          hold;
        exp_t        e;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference model: range checks done on signed integers rather than bit patterns.
    function automatic exp_t model(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                                   input logic [31:0] v, input logic [31:0] pc);
        exp_t   e;
        longint sv;
        longint d;
        longint npc;
        e   = '{n: 1, w0: 32'h0, w1: 32'h0, err: 1'b0};
        npc = (longint'(pc) + 64'sd4) % 64'sd4294967296;
        if (op == 3'd0) begin
            sv = longint'($signed(v));
            if (sv >= -64'sd32768 && sv <= 64'sd32767)
                e.w0 = 32'h24000000 + (32'(rt) * 32'h10000) + (v % 32'h10000);
            else if (v < 32'h10000)
                e.w0 = 32'h34000000 + (32'(rt) * 32'h10000) + v;
            else if (v % 32'h10000 == 32'h0)
                e.w0 = 32'h3C000000 + (32'(rt) * 32'h10000) + (v / 32'h10000);
            else begin
                e.n  = 2;
                e.w0 = 32'h3C000000 + (32'(rt) * 32'h10000) + (v / 32'h10000);
                e.w1 = 32'h34000000 + (32'(rt) * 32'h200000) + (32'(rt) * 32'h10000) + (v % 32'h10000);
            end
        end else if (op == 3'd1) begin
            d = longint'(v) - npc;
            if (d >= 64'sd2147483648) d = d - 64'sd4294967296;
            if (d < -64'sd2147483648) d = d + 64'sd4294967296;
            if ((d % 64'sd4 == 64'sd0) && d >= -64'sd131072 && d <= 64'sd131071)
                e.w0 = 32'h10000000 + (32'(rs) * 32'h200000) + (32'(rt) * 32'h10000)
                       + 32'((d / 64'sd4) & 64'sd65535);
            else
                e.err = 1'b1;
        end else if (op == 3'd2) begin
            if ((v % 32'd4 == 32'd0) && ((longint'(v) / 64'sd268435456) == (npc / 64'sd268435456)))
                e.w0 = 32'h08000000 + (v % 32'h10000000) / 32'd4;
            else
                e.err = 1'b1;
        end else begin
            e.err = 1'b1;
        end
        return e;
    endfunction

    task automatic send(input logic [2:0] op, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [31:0] v, input logic [31:0] pc);
        int waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL req_ready_timeout actual=0 required=1");
        end
        req_valid = 1'b1;
        req_op = op; req_rs = rs; req_rt = rt; req_value = v; req_pc = pc;
        @(negedge clk);
        req_valid = 1'b0;
        req_value = ~v;
    endtask

    // Called at the negedge right after acceptance; consumes all words of the request.
    task automatic recv(input string name, input exp_t e, input int hold);
        logic [31:0] w;
        for (int k = 0; k < e.n; k++) begin
            int waited = 0;
            while (!ins_valid && waited < 20) begin
                @(negedge clk);
                waited++;
            end
            w = (k == 0) ? e.w0 : e.w1;
            chk({name, "_valid"}, 32'(ins_valid), 32'd1);
            for (int h = 0; h < hold; h++) begin
                chk({name, "_hold_word"}, ins_word, w);
                chk({name, "_hold_req_ready"}, 32'(req_ready), 32'd0);
                @(negedge clk);
            end
            chk({name, "_word"}, ins_word, w);
            chk({name, "_last"}, 32'(ins_last), 32'(k == e.n - 1));
            chk({name, "_err"}, 32'(ins_err), (k == 0) ? 32'(e.err) : 32'd0);
            ins_ready = 1'b1;
            @(negedge clk);
            ins_ready = 1'b0;
        end
        chk({name, "_done_ready"}, 32'(req_ready), 32'd1);
        chk({name, "_done_valid"}, 32'(ins_valid), 32'd0);
    endtask

    vec_t        vecs[$];
    logic [31:0] acc_cyc[$];
    logic [31:0] got[$];
    logic [31:0] exp_words[4];
    logic [31:0] bb_val[4];

    initial begin
        rst = 1'b1; req_valid = 1'b0; ins_ready = 1'b0;
        req_op = 3'd0; req_rs = 5'd0; req_rt = 5'd0; req_value = 32'h0; req_pc = 32'h0;
        @(negedge clk); @(negedge clk);
        chk("reset_req_ready", 32'(req_ready), 32'd1);
        chk("reset_ins_valid", 32'(ins_valid), 32'd0);
        chk("reset_ins_word", ins_word, 32'h0);
        chk("reset_ins_last", 32'(ins_last), 32'd0);
        chk("reset_ins_err", 32'(ins_err), 32'd0);
        rst = 1'b0;

        vecs.push_back('{3'd0, 5'd0, 5'd8, 32'hFFFF8000, 32'h0, 0, '{1, 32'h24088000, 32'h0, 1'b0}});
        vecs.push_back('{3'd0, 5'd0, 5'd2, 32'h0000ABCD, 32'h0, 0, '{1, 32'h3402ABCD, 32'h0, 1'b0}});
        vecs.push_back('{3'd0, 5'd0, 5'd3, 32'h00010000, 32'h0, 0, '{1, 32'h3C030001, 32'h0, 1'b0}});
        vecs.push_back('{3'd0, 5'd0, 5'd9, 32'h12345678, 32'h0, 3, '{2, 32'h3C091234, 32'h35295678, 1'b0}});
        vecs.push_back('{3'd1, 5'd1, 5'd2, 32'h00400010, 32'h00400000, 0, '{1, 32'h10220003, 32'h0, 1'b0}});
        vecs.push_back('{3'd1, 5'd1, 5'd2, 32'h00400002, 32'h00400000, 1, '{1, 32'h0, 32'h0, 1'b1}});
        vecs.push_back('{3'd1, 5'd1, 5'd2, 32'h00440000, 32'h00400000, 0, '{1, 32'h0, 32'h0, 1'b1}});
        vecs.push_back('{3'd1, 5'd3, 5'd4, 32'h003FFFF0, 32'h00400000, 0, '{1, 32'h1064FFFB, 32'h0, 1'b0}});
        vecs.push_back('{3'd2, 5'd0, 5'd0, 32'h00400100, 32'h00400000, 0, '{1, 32'h08100040, 32'h0, 1'b0}});
        vecs.push_back('{3'd2, 5'd0, 5'd0, 32'h10000000, 32'h00400000, 0, '{1, 32'h0, 32'h0, 1'b1}});
        vecs.push_back('{3'd7, 5'd0, 5'd0, 32'h00000004, 32'h00400000, 0, '{1, 32'h0, 32'h0, 1'b1}});
        foreach (vecs[i]) begin
            send(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].value, vecs[i].pc);
            recv($sformatf("vec%0d", i), vecs[i].e, vecs[i].hold);
        end

        // Random requests against the model, with occasional backpressure.
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  op;
            logic [4:0]  rs;
            logic [4:0]  rt;
            logic [31:0] v;
            logic [31:0] pc;
            op = 3'($urandom_range(0, 3));
            rs = 5'($urandom); rt = 5'($urandom);
            pc = $urandom & 32'hFFFFFFFC;
            case ($urandom_range(0, 3))
                0: v = $urandom;
                1: v = 32'($signed(16'($urandom)));
                2: v = pc + 32'd4 + 32'($signed(19'($urandom)));
                default: v = {pc[31:28], 28'($urandom)} + 32'd4;
            endcase
            send(op, rs, rt, v, pc);
            recv($sformatf("rand%0d", i), model(op, rs, rt, v, pc), int'($urandom_range(0, 2)));
        end

        // Reset during EMIT1 of a two-word LI, with ins_ready high at the same edge.
        send(3'd0, 5'd0, 5'd9, 32'h12345678, 32'h0);
        chk("rst_pre_valid", 32'(ins_valid), 32'd1);
        rst = 1'b1; ins_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0; ins_ready = 1'b0;
        chk("rst_ins_valid", 32'(ins_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_ins_word", ins_word, 32'h0);
        begin
            int seen = 0;
            ins_ready = 1'b1;
            for (int c = 0; c < 4; c++) begin
                if (ins_valid) seen++;
                @(negedge clk);
            end
            ins_ready = 1'b0;
            chk("rst_no_second_word", 32'(seen), 32'd0);
        end
        send(3'd0, 5'd0, 5'd4, 32'h00000005, 32'h0);
        recv("post_rst_li", '{1, 32'h24040005, 32'h0, 1'b0}, 0);

        // Back-to-back single-word requests with both sides held high.
        bb_val = '{32'h00000011, 32'h0000F00D, 32'hABCD0000, 32'hFFFFFFFE};
        foreach (bb_val[i]) exp_words[i] = model(3'd0, 5'd0, 5'(i + 5), bb_val[i], 32'h0).w0;
        @(negedge clk);
        begin
            int idx = 0;
            req_valid = 1'b1; ins_ready = 1'b1;
            req_op = 3'd0; req_rt = 5'd5; req_value = bb_val[0];
            for (int c = 0; c < 14; c++) begin
                logic acc;
                if (ins_valid) got.push_back(ins_word);
                acc = req_ready && req_valid;
                if (acc) acc_cyc.push_back(32'(c));
                @(posedge clk);
                #1;
                if (acc) begin
                    idx++;
                    if (idx < 4) begin
                        req_rt = 5'(idx + 5);
                        req_value = bb_val[idx];
                    end else begin
                        req_valid = 1'b0;
                    end
                end
                @(negedge clk);
            end
            ins_ready = 1'b0;
        end
        chk("bb_accept_count", 32'(acc_cyc.size()), 32'd4);
        chk("bb_word_count", 32'(got.size()), 32'd4);
        for (int i = 1; i < 4 && i < acc_cyc.size(); i++)
            chk($sformatf("bb_accept_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 32'd2);
        for (int i = 0; i < 4 && i < got.size(); i++)
            chk($sformatf("bb_word%0d", i), got[i], exp_words[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ins_synth.md
# ins_synth

Instruction synthesizer for the debug/boot instruction-injection path. It is the encode-side counterpart of the decode-stage immediate extender. It takes a requested operation with a full 32-bit value (constant, branch target, or jump target), picks the shortest legal MIPS encoding, and packs the value back into the 16/26-bit instruction fields. Encoded words stream out over a valid/ready handshake, one or two words per request, to the injection FIFO in front of IF.

## Interface
Parameters: none.

- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request (high only in IDLE)
- req_op  in  3  3'b000 LI (load 32-bit constant), 3'b001 BEQ, 3'b010 J; other codes illegal
- req_rs  in  5  source register (BEQ only)
- req_rt  in  5  destination register (LI) / second compare register (BEQ)
- req_value  in  32  constant (LI) or absolute byte target address (BEQ, J)
- req_pc  in  32  address of the instruction being synthesized (BEQ, J)
- ins_valid  out  1  ins_word valid
- ins_ready  in  1  consumer accepts ins_word
- ins_word  out  32  encoded instruction
- ins_last  out  1  ins_word is the final word of this request
- ins_err  out  1  request could not be encoded; ins_word = 32'h0 (nop)

## Operation
- FSM states: IDLE, EMIT1, EMIT2.
- IDLE: req_ready=1. On req_valid, latch and encode the request, then go to EMIT1.
- EMIT1: ins_valid=1 and word 0 is held stable. On ins_ready, go to EMIT2 if the request needs two words, else go to IDLE.
- EMIT2: ins_valid=1, word 1, ins_last=1. On ins_ready, go to IDLE.
- LI encoding, first matching rule wins:
  - value[31:15] all equal: addiu rt,$0,value[15:0] (opcode 6'h09).
  - value[31:16]==0: ori rt,$0,value[15:0] (6'h0D).
  - value[15:0]==0: lui rt,value[31:16] (6'h0F).
  - otherwise two words: lui rt,value[31:16], then ori rt,rt,value[15:0].
- BEQ encoding:
  - diff = req_value − (req_pc+4), modulo 2^32.
  - Legal when diff[1:0]==0 and diff[31:17] all equal diff[17].
  - Word = {6'h04, rs, rt, diff[17:2]}.
- J encoding:
  - Legal when value[1:0]==0 and value[31:28]==(req_pc+4)[31:28].
  - Word = {6'h02, value[27:2]}.
- Illegal request (illegal op, misaligned target, or out-of-range target): emit a single word 32'h0 with ins_err=1 and ins_last=1.
- rs/rt fields are used verbatim; rt=0 is not rejected.

## Timing
- Reset values: state=IDLE, req_ready=1, ins_valid=0, ins_word=0, ins_last=0, ins_err=0.
- Latency: request accepted in cycle N, so ins_valid=1 in cycle N+1. All outputs are registered, with no combinational path from the req_* inputs to the ins_* outputs.
- ins_word, ins_last and ins_err stay stable while ins_valid=1 && ins_ready=0, for unlimited backpressure.
- ins_ready is ignored while ins_valid=0.
- Second word: ins_valid stays high across the EMIT1→EMIT2 edge, and word 1 appears the cycle after word 0 is handshaken.
- req_ready returns to 1 the cycle after the last handshake, with no same-cycle re-accept. Peak throughput is one single-word request per 2 cycles.
- Request inputs are sampled only on acceptance. Changes to them while busy have no effect.
- rst mid-operation (EMIT1 or EMIT2): the next cycle is IDLE with all outputs at reset values. A pending second word is dropped.
- rst takes priority over a simultaneous handshake.

## Test plan
- LI rt=8, value 0xFFFF8000: one word 0x24088000, last=1, err=0. Separately, rt=2 value 0x0000ABCD gives 0x3402ABCD, and rt=3 value 0x00010000 gives 0x3C030001.
- LI rt=9, value 0x12345678: 0x3C091234 with last=0, then 0x35295678 with last=1. Hold ins_ready low for 3 cycles on each word; the words must stay stable and req_ready must stay 0 throughout.
- BEQ rs=1, rt=2, pc=0x00400000, target 0x00400010: 0x10220003. Target 0x00400002 (misaligned) gives word 0, err=1, last=1. Target 0x00440000 (out of range) gives err=1.
- J pc=0x00400000, target 0x00400100: 0x08100040. Target 0x10000000 (region mismatch) gives err=1. req_op=3'b111 gives err=1.
- Reset in EMIT1 of a two-word LI: the next cycle has ins_valid=0 and req_ready=1, and no second word ever appears. A following LI 0x00000005 rt=4 yields 0x24040005.
- Back-to-back: hold req_valid continuously and ins_ready continuously high with four single-word requests. Check one acceptance every 2 cycles, words emitted in order, and no duplicated or lost request.
